// File: rtl/mux_select_sequencer.sv
// rtl/mux_select_sequencer.sv - select sequencer and frame sampler for a 3-to-1 bit mux
//
// Steps the mux select through channels 0, 1 and 2, holding each channel for
// DWELL cycles. At the end of each dwell it samples the fed-back mux output,
// so that every three dwells a 3-bit frame is assembled. It can run a single
// frame or scan continuously until a stop request is seen.
//
// Ports:
//   i_clk          clock, rising edge
//   i_rst_n        asynchronous active-low reset
//   i_start        one-cycle scan request, accepted only when idle
//   i_stop         end scanning once the current frame completes
//   i_mode         0 = single frame, 1 = continuous (latched on start)
//   i_mux_out      mux output fed back for sampling
//   o_sel          mux select, 0..2
//   o_sample       frame register, bit n = sample taken while o_sel == n
//   o_frame_valid  one-cycle pulse when o_sample holds a new complete frame
//   o_busy         high while scanning

module mux_select_sequencer #(
  parameter int DWELL = 4,
  parameter int CNT_W = 8
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_start,
  input  logic       i_stop,
  input  logic       i_mode,
  input  logic       i_mux_out,
  output logic [1:0] o_sel,
  output logic [2:0] o_sample,
  output logic       o_frame_valid,
  output logic       o_busy
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             mode_q;
  logic             stop_flag;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      mode_q        <= 1'b0;
      stop_flag     <= 1'b0;
      o_sel         <= 2'd0;
      o_sample      <= 3'b000;
      o_frame_valid <= 1'b0;
      o_busy        <= 1'b0;
    end else begin
      o_frame_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          o_sel  <= 2'd0;
          o_busy <= 1'b0;
          // A simultaneous stop vetoes the start.
          if (i_start && !i_stop) begin
            state     <= ST_SCAN;
            cnt       <= '0;
            o_busy    <= 1'b1;
            mode_q    <= i_mode;
            stop_flag <= 1'b0;
          end
        end

        ST_SCAN: begin
          if (i_stop) begin
            stop_flag <= 1'b1;
          end

          if (cnt == DWELL_LAST) begin
            cnt <= '0;
            case (o_sel)
              2'd0:    o_sample[0] <= i_mux_out;
              2'd1:    o_sample[1] <= i_mux_out;
              default: o_sample[2] <= i_mux_out;
            endcase

            if (o_sel == 2'd2) begin
              o_sel         <= 2'd0;
              o_frame_valid <= 1'b1;
              // A stop arriving on the wrap edge itself still ends this frame.
              if (!mode_q || stop_flag || i_stop) begin
                state     <= ST_IDLE;
                o_busy    <= 1'b0;
                stop_flag <= 1'b0;
              end
            end else begin
              o_sel <= o_sel + 2'd1;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
